// File: rtl/dds_nco.sv
// Quadrature NCO: phase accumulator, QPSK offset, quarter-wave sine table, sign stage.
// Optional macro DDS_NCO_DITHER_EN adds a 16-bit LFSR phase dither ahead of the table.
module dds_nco #(
    parameter int unsigned       ACC_W       = 32,
    parameter logic [ACC_W-1:0]  DEFAULT_FTW = ACC_W'(32'h0100_0000)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    input  logic [ACC_W-1:0]    ftw_in,
    input  logic                ftw_load,
    input  logic [1:0]          sym_in,
    input  logic                sym_load,
    input  logic                phase_clr,
    output logic signed [7:0]   sin_out,
    output logic signed [7:0]   cos_out,
    output logic                sample_valid
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] ftw;
    logic [1:0]       sym;
    logic [7:0]       p1;
    logic             v1;
    logic [6:0]       sin_mag;
    logic [6:0]       cos_mag;
    logic             sin_neg;
    logic             cos_neg;
    logic             v2;
    logic [7:0]       base_addr;
    logic [7:0]       cos_addr;

    // round(127*sin(2*pi*k/256)) for k = 0..64
    function automatic logic [6:0] quarter_sine(input logic [6:0] k);
        logic [6:0] t;
        t = 7'd0;
        case (k)
            7'd0:  t = 7'd0;   7'd1:  t = 7'd3;   7'd2:  t = 7'd6;   7'd3:  t = 7'd9;
            7'd4:  t = 7'd12;  7'd5:  t = 7'd16;  7'd6:  t = 7'd19;  7'd7:  t = 7'd22;
            7'd8:  t = 7'd25;  7'd9:  t = 7'd28;  7'd10: t = 7'd31;  7'd11: t = 7'd34;
            7'd12: t = 7'd37;  7'd13: t = 7'd40;  7'd14: t = 7'd43;  7'd15: t = 7'd46;
            7'd16: t = 7'd49;  7'd17: t = 7'd51;  7'd18: t = 7'd54;  7'd19: t = 7'd57;
            7'd20: t = 7'd60;  7'd21: t = 7'd63;  7'd22: t = 7'd65;  7'd23: t = 7'd68;
            7'd24: t = 7'd71;  7'd25: t = 7'd73;  7'd26: t = 7'd76;  7'd27: t = 7'd78;
            7'd28: t = 7'd81;  7'd29: t = 7'd83;  7'd30: t = 7'd85;  7'd31: t = 7'd88;
            7'd32: t = 7'd90;  7'd33: t = 7'd92;  7'd34: t = 7'd94;  7'd35: t = 7'd96;
            7'd36: t = 7'd98;  7'd37: t = 7'd100; 7'd38: t = 7'd102; 7'd39: t = 7'd104;
            7'd40: t = 7'd106; 7'd41: t = 7'd107; 7'd42: t = 7'd109; 7'd43: t = 7'd111;
            7'd44: t = 7'd112; 7'd45: t = 7'd113; 7'd46: t = 7'd115; 7'd47: t = 7'd116;
            7'd48: t = 7'd117; 7'd49: t = 7'd118; 7'd50: t = 7'd120; 7'd51: t = 7'd121;
            7'd52: t = 7'd122; 7'd53: t = 7'd122; 7'd54: t = 7'd123; 7'd55: t = 7'd124;
            7'd56: t = 7'd125; 7'd57: t = 7'd125; 7'd58: t = 7'd126; 7'd59: t = 7'd126;
            7'd60: t = 7'd126; 7'd61: t = 7'd127; 7'd62: t = 7'd127; 7'd63: t = 7'd127;
            7'd64: t = 7'd127;
            default: t = 7'd0;
        endcase
        return t;
    endfunction

    // Odd quadrants read the quarter table mirrored about index 64.
    function automatic logic [6:0] table_mag(input logic [7:0] a);
        logic [6:0] k;
        k = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
        return quarter_sine(k);
    endfunction

`ifdef DDS_NCO_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else if (ce) begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    // Dither only perturbs the table address; the accumulator stays exact.
    assign base_addr = 8'((acc + (ACC_W'(lfsr) << 8)) >> (ACC_W - 8));
`else
    assign base_addr = acc[ACC_W-1 -: 8];
`endif

    assign cos_addr = p1 + 8'd64;

    // NOTE: sequential state uses <= so every stage samples the pre-edge value of its predecessor.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            ftw <= DEFAULT_FTW;
            sym <= 2'd0;
        end else begin
            if (phase_clr) begin
                acc <= '0;
            end else if (ce) begin
                acc <= acc + ftw;
            end
            if (ftw_load) begin
                ftw <= ftw_in;
            end
            if (sym_load) begin
                sym <= sym_in;
            end
        end
    end

    // NOTE: stages 2/3 load only behind a valid sample, so outputs hold while ce is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p1           <= 8'd0;
            v1           <= 1'b0;
            sin_mag      <= 7'd0;
            cos_mag      <= 7'd0;
            sin_neg      <= 1'b0;
            cos_neg      <= 1'b0;
            v2           <= 1'b0;
            sin_out      <= 8'sd0;
            cos_out      <= 8'sd0;
            sample_valid <= 1'b0;
        end else begin
            v1           <= ce;
            v2           <= v1;
            sample_valid <= v2;
            if (ce) begin
                p1 <= base_addr + {sym, 6'b0};
            end
            if (v1) begin
                sin_mag <= table_mag(p1);
                cos_mag <= table_mag(cos_addr);
                sin_neg <= p1[7];
                cos_neg <= cos_addr[7];
            end
            if (v2) begin
                sin_out <= sin_neg ? -$signed({1'b0, sin_mag}) : $signed({1'b0, sin_mag});
                cos_out <= cos_neg ? -$signed({1'b0, cos_mag}) : $signed({1'b0, cos_mag});
            end
        end
    end

endmodule

// File: tb/tb_dds_nco.sv
// Self-checking bench for dds_nco: directed steps plus random traffic against a
// real-arithmetic sine model with a sample delay line.
module tb_dds_nco;

    localparam int          ACC_W       = 32;
    localparam logic [31:0] DEFAULT_FTW = 32'h0100_0000;
    localparam real         PI          = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ce;
    logic [ACC_W-1:0]   ftw_in;
    logic               ftw_load;
    logic [1:0]         sym_in;
    logic               sym_load;
    logic               phase_clr;
    logic signed [7:0]  sin_out;
    logic signed [7:0]  cos_out;
    logic               sample_valid;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic              v;
        logic signed [7:0] s;
        logic signed [7:0] c;
    } samp_t;

    samp_t             pipe [2];
    logic [31:0]       m_acc;
    logic [31:0]       m_ftw;
    logic [1:0]        m_sym;
    logic [15:0]       m_lfsr;
    logic              exp_valid;
    logic signed [7:0] exp_sin;
    logic signed [7:0] exp_cos;
    logic signed [7:0] sym_sin [4];
    logic signed [7:0] sym_cos [4];

    dds_nco #(.ACC_W(ACC_W), .DEFAULT_FTW(DEFAULT_FTW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ce           (ce),
        .ftw_in       (ftw_in),
        .ftw_load     (ftw_load),
        .sym_in       (sym_in),
        .sym_load     (sym_load),
        .phase_clr    (phase_clr),
        .sin_out      (sin_out),
        .cos_out      (cos_out),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    // round(127*sin(2*pi*a/256)) computed directly over the full circle
    function automatic logic signed [7:0] ref_wave(input int a);
        real v;
        int  r;
        v = 127.0 * $sin(2.0 * PI * real'(a % 256) / 256.0);
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else          r = -$rtoi(-v + 0.5);
        return 8'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    // Reference behaviour at one rising edge, using the inputs held across it.
    task automatic model_edge();
        samp_t ns;
        int    addr;
        if (!rst_n) begin
            m_acc     = 32'd0;
            m_ftw     = DEFAULT_FTW;
            m_sym     = 2'd0;
            m_lfsr    = 16'hACE1;
            pipe[0]   = '{1'b0, 8'sd0, 8'sd0};
            pipe[1]   = '{1'b0, 8'sd0, 8'sd0};
            exp_valid = 1'b0;
            exp_sin   = 8'sd0;
            exp_cos   = 8'sd0;
            return;
        end
`ifdef DDS_NCO_DITHER_EN
        addr = int'(((m_acc + ({16'd0, m_lfsr} << 8)) >> 24) & 32'hFF);
`else
        addr = int'(m_acc >> 24);
`endif
        addr = (addr + 64 * int'(m_sym)) % 256;
        ns.v = ce;
        ns.s = ref_wave(addr);
        ns.c = ref_wave(addr + 64);
        exp_valid = pipe[1].v;
        if (pipe[1].v) begin
            exp_sin = pipe[1].s;
            exp_cos = pipe[1].c;
        end
        pipe[1] = pipe[0];
        pipe[0] = ns;
`ifdef DDS_NCO_DITHER_EN
        if (ce) m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
        if (phase_clr)   m_acc = 32'd0;
        else if (ce)     m_acc = m_acc + m_ftw;
        if (ftw_load)    m_ftw = ftw_in;
        if (sym_load)    m_sym = sym_in;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("valid", 32'(sample_valid), 32'(exp_valid));
        chk("sin", 32'(sin_out), 32'(exp_sin));
        chk("cos", 32'(cos_out), 32'(exp_cos));
        chk("no_neg128", 32'((sin_out != -8'sd128) && (cos_out != -8'sd128)), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic idle_controls();
        ftw_load  = 1'b0;
        sym_load  = 1'b0;
        phase_clr = 1'b0;
    endtask

    initial begin
        sym_sin = '{8'sd0, 8'sd127, 8'sd0, -8'sd127};
        sym_cos = '{8'sd127, 8'sd0, -8'sd127, 8'sd0};
        rst_n = 1'b0; ce = 1'b0; ftw_in = '0; sym_in = 2'd0;
        idle_controls();

        // Reset state
        run(2);
        chk("rst_sin", 32'(sin_out), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);

        // Default FTW, continuous ce: first valid sample after three edges
        rst_n = 1'b1; ce = 1'b1;
        run(2);
        chk("pre_first_valid", 32'(sample_valid), 32'd0);
        step();
        chk("first_valid", 32'(sample_valid), 32'd1);
        chk("first_sin", 32'(sin_out), 32'd0);
        chk("first_cos", 32'(cos_out), 32'(8'sd127));
        step();
        chk("second_sin", 32'(sin_out), 32'(8'sd3));
        run(520);

        // Quarter-turn FTW after a clear: 0,127,0,-127 pattern
        ftw_in = 32'h4000_0000; ftw_load = 1'b1; phase_clr = 1'b1;
        step();
        idle_controls();
        run(16);

        // FTW=0 and each QPSK symbol in turn
        ftw_in = 32'd0; ftw_load = 1'b1; phase_clr = 1'b1;
        step();
        idle_controls();
        run(4);
        for (int s = 1; s < 4; s++) begin
            sym_in = 2'(s); sym_load = 1'b1;
            step();
            sym_load = 1'b0;
            run(4);
            chk("sym_sin", 32'(sin_out), 32'(sym_sin[s]));
            chk("sym_cos", 32'(cos_out), 32'(sym_cos[s]));
        end
        sym_in = 2'd0; sym_load = 1'b1;
        step();
        sym_load = 1'b0;

        // Wrap downward through zero with the largest FTW
        ftw_in = 32'hFFFF_FFFF; ftw_load = 1'b1; phase_clr = 1'b1;
        step();
        idle_controls();
        run(12);
        // Approach the top of the range and wrap upward
        ftw_in = 32'h0F00_0001; ftw_load = 1'b1;
        step();
        idle_controls();
        run(40);

        // ce toggling, then clear coincident with ce
        ftw_in = 32'h0300_0000; ftw_load = 1'b1;
        step();
        idle_controls();
        for (int i = 0; i < 12; i++) begin
            ce = (i % 2 == 0);
            step();
        end
        ce = 1'b1;
        run(5);
        phase_clr = 1'b1;
        step();
        phase_clr = 1'b0;
        run(6);

        // One-cycle reset mid-stream
        rst_n = 1'b0;
        step();
        chk("midrst_sin", 32'(sin_out), 32'd0);
        chk("midrst_cos", 32'(cos_out), 32'd0);
        chk("midrst_valid", 32'(sample_valid), 32'd0);
        rst_n = 1'b1;
        run(3);
        chk("restart_sin", 32'(sin_out), 32'd0);
        chk("restart_valid", 32'(sample_valid), 32'd1);
        step();
        chk("restart_sin2", 32'(sin_out), 32'(8'sd3));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            ce        = ($urandom_range(0, 3) != 0);
            ftw_load  = ($urandom_range(0, 15) == 0);
            ftw_in    = ($urandom_range(0, 1) == 0) ? $urandom() : ($urandom() >> 4);
            sym_load  = ($urandom_range(0, 7) == 0);
            sym_in    = 2'($urandom_range(0, 3));
            phase_clr = ($urandom_range(0, 31) == 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1; ce = 1'b0;
        idle_controls();
        run(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dds_nco.md
Name: dds_nco

Overview:
- Quadrature numerically controlled oscillator for the QPSK modulator carrier path.
- Phase accumulator, QPSK phase-offset adder, quarter-wave sine table, sign stage.
- Emits 8-bit two's-complement sin/cos samples in the range -127..+127.
- Sits directly upstream of the offset-binary converter that feeds the DAC.

Parameters:
- ACC_W, 32, phase accumulator width; address = acc[ACC_W-1 -: 8].
- DEFAULT_FTW, 32'h0100_0000, FTW loaded at reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- ce  in  1  sample enable; one accumulator step and one output sample per asserted cycle.
- ftw_in  in  ACC_W  frequency tuning word.
- ftw_load  in  1  capture ftw_in.
- sym_in  in  2  QPSK symbol; phase offset = sym × 90°.
- sym_load  in  1  capture sym_in.
- phase_clr  in  1  synchronous accumulator clear.
- sin_out  out  8  signed sine sample.
- cos_out  out  8  signed cosine sample.
- sample_valid  out  1  sin_out/cos_out valid this cycle.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - acc=0, ftw=DEFAULT_FTW, sym=0.
  - All pipeline registers cleared; sin_out=0, cos_out=0, sample_valid=0.
  - Dither LFSR (if present) = 16'hACE1.
  - Reset mid-pipeline discards every in-flight sample.
- FTW register:
  - On ftw_load, ftw<=ftw_in.
  - An accumulation in the same cycle uses the old ftw.
- Symbol register:
  - On sym_load, sym<=sym_in.
  - Takes effect for the first ce strictly after the load cycle.
- Accumulator (each edge, in priority order):
  - phase_clr → acc<=0.
  - else ce → acc<=acc+ftw, modulo 2^ACC_W; wraps silently.
  - phase_clr and ce together: acc<=0; the sample for that ce is still issued, using the pre-clear acc.
- Stage 1 (on ce): p1 <= acc[ACC_W-1 -: 8] + {sym,6'b0}, mod 256 (dithered variant: see Optional Feature). A ce sample is taken from acc before its update.
- Stage 2 (table lookup):
  - Table: T[k] = round(127·sin(2πk/256)), k=0..64, 65 entries, 7-bit unsigned; T[0]=0, T[64]=127.
  - For address a: q=a[7:6], i=a[5:0].
  - mag = T[i] for q=0 or 2; mag = T[64-i] for q=1 or 3.
  - neg = q[1].
  - Sine uses a=p1; cosine uses a=p1+64 (mod 256).
  - Magnitude and sign are registered.
- Stage 3: out = neg ? -mag : mag, registered into sin_out/cos_out.
- Latency and validity:
  - sample_valid is a 3-stage delay of ce.
  - Sample for ce at cycle n appears with sample_valid=1 at cycle n+3.
  - Stages advance every cycle; ce only qualifies them.
  - With ce=0, sample_valid=0 and outputs hold their last value.
- Output properties: values never reach -128; sin²+cos² is consistent (both from the same table).

Optional Feature:
- Macro: DDS_NCO_DITHER_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1, advances once per ce.
  - Stage 1 address becomes (acc + {8'b0, lfsr, 8'b0})[31:24] + {sym,6'b0}.
  - The accumulator itself is never dithered.
  - Spreads truncation spurs.
- Undefined: no LFSR hardware; output is bit-exact to the table mapping above.

Test Plan:
- Reset, then ftw=2^24, ce=1 continuous, sym=0 → first sample_valid at cycle 3; sin_out sequence 0,3,6,9,… and cos_out 127,127,127,127,…; after 256 samples the sequence repeats exactly.
- ftw_load ftw_in=2^30, phase_clr, ce continuous → sin 0,127,0,-127 repeating; cos 127,0,-127,0 repeating; -128 never output.
- ftw=0, sym_load with sym_in=1,2,3 in turn → sin_out settles to 127, 0, -127; cos_out to 0, -127, 0, each taking effect on the first ce after the load.
- ftw=32'hFFFF_FFFF with acc near wrap → acc wraps to a small value without glitches; address decrements by at most 1 per sample.
- ce toggled 1,0,1,0 → sample_valid mirrors ce delayed by exactly 3 cycles; acc advances only on ce cycles; phase_clr+ce on the same cycle outputs the pre-clear sample and the next sample reads address 0.
- rst_n low for 1 cycle mid-stream → next cycle all outputs 0 and sample_valid 0; ftw returns to DEFAULT_FTW; the sequence restarts from sin=0. With DDS_NCO_DITHER_EN defined, the reset-to-reset sequence is reproducible.
